// File: rtl/data_stack.sv
// data_stack: LIFO cell stack for the Forth datapath with exposed top two cells and sticky error flags
// Ports: Clock/Reset (async, active-high); Op 00 hold, 01 push A, 10 pop, 11 replace top with A;
//        A cell input; ClearErr clears sticky flags; T/N top and second cell (0 when invalid);
//        Depth cell count; Empty/Full decodes; Overflow/Underflow sticky error flags.
module data_stack #(
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          Op,
  input  logic [3:0][0:2]     A,
  input  logic                ClearErr,
  output logic [3:0][0:2]     T,
  output logic [3:0][0:2]     N,
  output logic [DW-1:0]       Depth,
  output logic                Empty,
  output logic                Full,
  output logic                Overflow,
  output logic                Underflow
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [3:0][0:2] cell_t;
  cell_t         mem_q [DEPTH];
  cell_t         mem_d [DEPTH];
  logic [DW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  assign Empty     = sp_q == '0;
  assign Full      = sp_q == DW'(DEPTH);
  assign Depth     = sp_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  // Invalid cells read as zero so stale data never reaches the ALU
  assign T = Empty ? '0 : mem_q[AW'(sp_q - DW'(1))];
  assign N = (sp_q < DW'(2)) ? '0 : mem_q[AW'(sp_q - DW'(2))];
  // ClearErr drops the flags first so a same-cycle error event still sets its own flag
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    ovf_d = ovf_q & ~ClearErr;
    unf_d = unf_q & ~ClearErr;
    if (Op == 2'b01) begin
      if (Full) ovf_d = 1'b1;
      else begin
        mem_d[AW'(sp_q)] = A;
        sp_d = sp_q + DW'(1);
      end
    end
    else if (Op[1] && Empty) unf_d = 1'b1;
    else if (Op == 2'b10) sp_d = sp_q - DW'(1);
    else if (Op == 2'b11) mem_d[AW'(sp_q - DW'(1))] = A;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: scoreboard bench for data_stack against an array-based stack model
module tb_data_stack;
  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [1:0]      Op = 2'b00;
  logic [3:0][0:2] A = '0;
  logic            ClearErr = 1'b0;
  logic [3:0][0:2] T, N;
  logic [3:0]      Depth;
  logic            Empty, Full, Overflow, Underflow;
  always #5 Clock = ~Clock;
  data_stack #(.DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Op(Op), .A(A), .ClearErr(ClearErr),
    .T(T), .N(N), .Depth(Depth), .Empty(Empty), .Full(Full),
    .Overflow(Overflow), .Underflow(Underflow)
  );
  typedef logic [32:0] obs_t;
  localparam obs_t RST_OBS = {12'o0, 12'o0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [1:0] HOLD = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;
  obs_t        sb[$];
  obs_t        e;
  int          vecs = 0;
  int          errs = 0;
  logic [11:0] m_mem [8];
  int          m_sp = 0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  function automatic obs_t dut_obs();
    return {T, N, Depth, Empty, Full, Overflow, Underflow};
  endfunction
  function automatic obs_t m_obs();
    logic [11:0] t, n;
    t = (m_sp > 0) ? m_mem[m_sp-1] : 12'o0;
    n = (m_sp > 1) ? m_mem[m_sp-2] : 12'o0;
    return {t, n, 4'(m_sp), m_sp == 0, m_sp == 8, m_ovf, m_unf};
  endfunction
  task automatic m_reset();
    m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 12'o0;
  endtask
  task automatic apply(input logic [1:0] op, input logic [11:0] a, input logic clr);
    @(negedge Clock);
    Op = op; A = a; ClearErr = clr;
    m_ovf = m_ovf & ~clr;
    m_unf = m_unf & ~clr;
    case (op)
      PUSH: if (m_sp == 8) m_ovf = 1'b1; else begin m_mem[m_sp] = a; m_sp++; end
      POP:  if (m_sp == 0) m_unf = 1'b1; else m_sp--;
      REPL: if (m_sp == 0) m_unf = 1'b1; else m_mem[m_sp-1] = a;
      default: ;
    endcase
    sb.push_back(m_obs());
    @(posedge Clock);
    #1;
  endtask
  task automatic test_reset();
    #2;
    vecs++;
    if (dut_obs() !== RST_OBS) begin errs++; $display("FAIL reset: got %h exp %h", dut_obs(), RST_OBS); end
    @(negedge Clock);
    Reset = 1'b0;
    m_reset();
  endtask
  task automatic test_push();
    logic [11:0] v [2] = '{12'o1234, 12'o5670};
    for (int i = 0; i < 2; i++) begin
      apply(PUSH, v[i], 1'b0);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL push[%0d]: got %h exp %h", i, dut_obs(), e); end
    end
    vecs++;
    if ({T, N, Depth, Empty} !== {12'o5670, 12'o1234, 4'd2, 1'b0}) begin
      errs++; $display("FAIL push_tn: got T=%o N=%o D=%0d E=%b exp T=5670 N=1234 D=2 E=0", T, N, Depth, Empty);
    end
  endtask
  task automatic test_pop_underflow();
    for (int i = 0; i < 3; i++) begin
      apply(POP, 12'o0, 1'b0);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL pop[%0d]: got %h exp %h", i, dut_obs(), e); end
    end
    vecs++;
    if ({Underflow, Empty, Depth, T} !== {1'b1, 1'b1, 4'd0, 12'o0}) begin
      errs++; $display("FAIL underflow: got U=%b E=%b D=%0d T=%o exp U=1 E=1 D=0 T=0", Underflow, Empty, Depth, T);
    end
  endtask
  task automatic test_replace();
    logic [1:0]  ops [5] = '{HOLD, PUSH, REPL, POP, REPL};
    logic [11:0] val [5] = '{12'o0, 12'o0007, 12'o7777, 12'o0, 12'o1111};
    logic        clr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], val[i], clr[i]);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL replace[%0d]: got %h exp %h", i, dut_obs(), e); end
      if (i == 2) begin
        vecs++;
        if ({T, Depth} !== {12'o7777, 4'd1}) begin
          errs++; $display("FAIL replace_top: got T=%o D=%0d exp T=7777 D=1", T, Depth);
        end
      end
    end
    vecs++;
    if ({Underflow, Depth} !== {1'b1, 4'd0}) begin
      errs++; $display("FAIL replace_empty: got U=%b D=%0d exp U=1 D=0", Underflow, Depth);
    end
  endtask
  task automatic test_fill_overflow();
    for (int i = 1; i <= 10; i++) begin
      apply(i == 10 ? HOLD : PUSH, 12'(i), i == 1);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL fill[%0d]: got %h exp %h", i, dut_obs(), e); end
    end
    vecs++;
    if ({Full, Depth, T, Overflow} !== {1'b1, 4'd8, 12'o10, 1'b1}) begin
      errs++; $display("FAIL overflow: got F=%b D=%0d T=%o O=%b exp F=1 D=8 T=10 O=1", Full, Depth, T, Overflow);
    end
  endtask
  task automatic test_clear_collision();
    for (int i = 0; i < 10; i++) begin
      apply(i < 9 ? POP : HOLD, 12'o0, i >= 8);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL clear[%0d]: got %h exp %h", i, dut_obs(), e); end
      if (i == 8) begin
        vecs++;
        if ({Overflow, Underflow} !== 2'b01) begin
          errs++; $display("FAIL collision: got O=%b U=%b exp O=0 U=1", Overflow, Underflow);
        end
      end
    end
    vecs++;
    if ({Overflow, Underflow} !== 2'b00) begin
      errs++; $display("FAIL clear_only: got O=%b U=%b exp O=0 U=0", Overflow, Underflow);
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      apply(PUSH, 12'(100 + i), 1'b0);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL pre_reset[%0d]: got %h exp %h", i, dut_obs(), e); end
    end
    @(negedge Clock);
    Op = HOLD;
    #1 Reset = 1'b1;
    #1;
    vecs++;
    if (dut_obs() !== RST_OBS) begin errs++; $display("FAIL async_reset: got %h exp %h", dut_obs(), RST_OBS); end
    m_reset();
    @(negedge Clock);
    Reset = 1'b0;
    apply(PUSH, 12'o0001, 1'b0);
    e = sb.pop_front(); vecs++;
    if (dut_obs() !== e) begin errs++; $display("FAIL post_reset: got %h exp %h", dut_obs(), e); end
    vecs++;
    if ({Depth, T} !== {4'd1, 12'o0001}) begin
      errs++; $display("FAIL post_reset_push: got D=%0d T=%o exp D=1 T=1", Depth, T);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      apply(2'($urandom_range(0, 3)), 12'($urandom), $urandom_range(0, 7) == 0);
      e = sb.pop_front(); vecs++;
      if (dut_obs() !== e) begin errs++; $display("FAIL b2b[%0d]: got %h exp %h", i, dut_obs(), e); end
    end
  endtask
  initial begin
    test_reset();
    test_push();
    test_pop_underflow();
    test_replace();
    test_fill_overflow();
    test_clear_collision();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
